regfile_write_arbiter: RTL
==========================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of the register file write port.
REQ-002 SHALL have parameter DEPTH, default 32, number of architectural registers; address width AW = 5.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports r0_valid / r0_ready, input / output, 1 each: requester 0 (execute writeback) handshake.
REQ-006 SHALL have ports r0_addr / r0_data, input, AW / WIDTH: requester 0 destination and value.
REQ-007 SHALL have ports r1_valid / r1_ready / r1_addr / r1_data, same directions and widths: requester 1 (load writeback).
REQ-008 SHALL have ports rsv_valid / rsv_addr, input, 1 / AW: issue-stage reservation of a destination register.
REQ-009 SHALL have ports q1_addr / q2_addr, input, AW: source operands to check.
REQ-010 SHALL have ports q1_busy / q2_busy, output, 1: queried register has a pending write.
REQ-011 SHALL have ports WE3 / A3 / WD3, output, 1 / AW / WIDTH: registered write port driving the register file.

Function
REQ-012 A transfer on requester k SHALL occur in a cycle where rk_valid and rk_ready are both 1.
REQ-013 At most one of r0_ready / r1_ready SHALL be 1 per cycle; rk_ready is combinational from the valid inputs and the priority pointer and never depends on rk_ready of the other port.
REQ-014 With one requester valid, that requester SHALL be granted in the same cycle.
REQ-015 With both valid, the requester indicated by the priority pointer SHALL be granted; the pointer then moves to the other requester (round robin).
REQ-016 The pointer SHALL change only on a transfer; with no transfer it holds.
REQ-017 A transfer in cycle N SHALL produce WE3=1, A3=addr, WD3=data in cycle N+1; with no transfer in cycle N, WE3=0 in cycle N+1 and A3/WD3 hold.
REQ-018 A transfer with addr=0 SHALL complete its handshake but produce WE3=0 in cycle N+1.
REQ-019 The SHALL keep a DEPTH-bit busy vector; an rsv_valid with rsv_addr != 0 sets bit rsv_addr at the clock edge.
REQ-020 A transfer to addr != 0 SHALL clear busy[addr] at the clock edge ending cycle N.
REQ-021 If a reservation and a clearing transfer target the same register in the same cycle, the bit SHALL end set (reservation wins).
REQ-022 A reservation of an already-busy register SHALL leave it set; there is no count and no error flag.
REQ-023 qk_busy SHALL be busy[qk_addr] combinationally, with q addr 0 always returning 0.
REQ-024 qk_busy SHALL NOT reflect same-cycle reservations or transfers; it reflects the registered vector only.
REQ-025 A requester holding rk_valid without ready SHALL keep addr/data stable; the block does not check this.

Reset
REQ-026 While rst=1 at a rising edge: WE3=0, A3=0, WD3=0, busy vector all 0, and priority pointer = requester 0.
REQ-027 During reset cycles r0_ready and r1_ready SHALL be 0; no transfer, reservation or pointer update occurs.
REQ-028 Reset asserted with a write in flight SHALL drop that write: WE3=0 in the following cycle.

Structure
REQ-029 A shared package regfile_ctrl_pkg SHALL hold WIDTH/DEPTH/AW defaults and the requester index constants (REQ_EXE=0, REQ_LD=1).
REQ-030 Arbitration SHALL be a sub-module rr_arbiter2 (2 valid in, 2 grant out, pointer register, advance-on-transfer input).
REQ-031 Busy vector, output register and query logic SHALL stay in regfile_write_arbiter; target 150-300 RTL lines total.

Verification
REQ-032 Reset, then r0 valid addr=5 data=0xDEADBEEF alone -> r0_ready=1 same cycle; next cycle WE3=1, A3=5, WD3=0xDEADBEEF.
REQ-033 After reset, both valid for 4 cycles (r0 addr=1, r1 addr=2) -> grants r0,r1,r0,r1; A3 sequence 1,2,1,2 one cycle later.
REQ-034 r1 valid addr=0 data=0x1234 -> r1_ready=1; next cycle WE3=0; busy unchanged.
REQ-035 rsv addr=7; next cycle q1_addr=7 -> q1_busy=1; r0 writes addr=7 -> q1_busy=0 after that edge; same-cycle rsv 7 plus write 7 -> q1_busy stays 1.
REQ-036 rsv_addr=0 -> q2_addr=0 gives q2_busy=0; busy vector unchanged.
REQ-037 rst=1 in the cycle after a transfer to addr=3 with busy[3] set -> WE3=0 next cycle, busy all 0, and pointer back to requester 0 (both valid afterward grants r0 first).

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Shared constants for the register-file write path.
// Covers the default widths, the fixed address width and the requester indices.
package regfile_ctrl_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 32;
    localparam int AW        = 5;
    localparam int NUM_REQ   = 2;

    localparam logic REQ_EXE = 1'b0;
    localparam logic REQ_LD  = 1'b1;

    function automatic logic [NUM_REQ-1:0] idx_onehot(input logic idx);
        logic [NUM_REQ-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter.
// The grant is combinational from valid and the pointer, and the pointer moves only when advance is high.
module rr_arbiter2
    import regfile_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    logic ptr_reg;
    logic ptr_next;

    always_comb begin
        grant    = '0;
        ptr_next = ptr_reg;
        if (valid[ptr_reg]) begin
            grant = idx_onehot(ptr_reg);
        end else if (valid[~ptr_reg]) begin
            grant = idx_onehot(~ptr_reg);
        end
        // After a transfer, the other requester gets priority.
        if (advance) begin
            ptr_next = grant[REQ_EXE] ? REQ_LD : REQ_EXE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= REQ_EXE;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates execute and load writebacks onto a single registered register-file write port.
// It also tracks pending writes in a busy vector for operand hazard queries.
module regfile_write_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [AW-1:0]    r0_addr,
    input  logic [WIDTH-1:0] r0_data,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [AW-1:0]    r1_addr,
    input  logic [WIDTH-1:0] r1_data,
    input  logic             rsv_valid,
    input  logic [AW-1:0]    rsv_addr,
    input  logic [AW-1:0]    q1_addr,
    input  logic [AW-1:0]    q2_addr,
    output logic             q1_busy,
    output logic             q2_busy,
    output logic             WE3,
    output logic [AW-1:0]    A3,
    output logic [WIDTH-1:0] WD3
);

    logic [NUM_REQ-1:0] grant;
    logic               xfer;
    logic [AW-1:0]      xfer_addr;
    logic [WIDTH-1:0]   xfer_data;

    logic               we_reg;
    logic [AW-1:0]      a3_reg;
    logic [WIDTH-1:0]   wd3_reg;
    logic [DEPTH-1:0]   busy_reg;
    logic [DEPTH-1:0]   busy_next;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid   ({r1_valid, r0_valid}),
        .advance (xfer),
        .grant   (grant)
    );

    // Grants are masked during reset so no handshake can complete.
    assign r0_ready  = grant[REQ_EXE] & ~rst;
    assign r1_ready  = grant[REQ_LD]  & ~rst;
    assign xfer      = (r0_valid & r0_ready) | (r1_valid & r1_ready);
    assign xfer_addr = r1_ready ? r1_addr : r0_addr;
    assign xfer_data = r1_ready ? r1_data : r0_data;

    // A reservation in the same cycle as a clearing write leaves the bit set.
    // Register 0 is never busy.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
        if (gi == 0) begin : g_zero
            assign busy_next[gi] = 1'b0;
        end else begin : g_bit
            logic set_bit;
            logic clr_bit;
            assign set_bit       = rsv_valid && (rsv_addr == AW'(gi));
            assign clr_bit       = xfer && (xfer_addr == AW'(gi));
            assign busy_next[gi] = set_bit | (busy_reg[gi] & ~clr_bit);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_reg   <= 1'b0;
            a3_reg   <= '0;
            wd3_reg  <= '0;
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
            if (xfer) begin
                we_reg  <= (xfer_addr != '0);
                a3_reg  <= xfer_addr;
                wd3_reg <= xfer_data;
            end else begin
                we_reg  <= 1'b0;
            end
        end
    end

    assign WE3 = we_reg;
    assign A3  = a3_reg;
    assign WD3 = wd3_reg;

    assign q1_busy = (q1_addr != '0) && busy_reg[q1_addr];
    assign q2_busy = (q2_addr != '0) && busy_reg[q2_addr];

endmodule
